// File: rtl/fetch_unit.sv
// fetch_unit: FETCH/WAIT/EXEC instruction fetch FSM with next-PC selection.
// Macro FETCH_MISALIGN_TRAP_EN redirects misaligned targets to TRAP_VECTOR.
module fetch_unit #(
    parameter int WORD_BITWIDTH = 32,
    parameter logic [WORD_BITWIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [WORD_BITWIDTH-1:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     branch_en,
    input  logic [2:0]               branch_type,
    input  logic                     zero,
    input  logic                     lt,
    input  logic                     ltu,
    input  logic                     jal,
    input  logic                     jalr,
    input  logic [WORD_BITWIDTH-1:0] imm,
    input  logic [WORD_BITWIDTH-1:0] rs1,
    output logic                     imem_req,
    output logic [WORD_BITWIDTH-1:0] imem_addr,
    input  logic                     imem_rvalid,
    input  logic [WORD_BITWIDTH-1:0] imem_rdata,
    output logic [WORD_BITWIDTH-1:0] pc,
    output logic [WORD_BITWIDTH-1:0] instr,
    output logic                     instr_valid,
    output logic                     misalign
);

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_EXEC
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic                     started;
    logic                     taken;
    logic                     nonseq;
    logic                     trap;
    logic [WORD_BITWIDTH-1:0] target;
    logic [WORD_BITWIDTH-1:0] pc_next;
    logic                     advance;

    assign imem_addr = pc;
    assign advance   = (state == S_EXEC) && !stall;

    // State register; started holds off the first request until one edge after reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_FETCH;
            started <= 1'b0;
        end else begin
            state   <= state_next;
            started <= 1'b1;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next  = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        unique case (state)
            S_FETCH: begin
                if (started) begin
                    imem_req   = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) state_next = S_EXEC;
            end
            S_EXEC: begin
                instr_valid = 1'b1;
                if (!stall) state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Branch condition decode
    always_comb begin
        taken = 1'b0;
        case (branch_type)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase
        taken = taken && branch_en;
    end

    // Next-PC selection: jalr > jal > taken branch > sequential
    always_comb begin
        nonseq = 1'b1;
        target = pc + WORD_BITWIDTH'(4);
        priority case (1'b1)
            jalr:        target = (rs1 + imm) & ~WORD_BITWIDTH'(1);
            jal, taken:  target = pc + imm;
            default: begin
                nonseq = 1'b0;
                target = pc + WORD_BITWIDTH'(4);
            end
        endcase
        trap    = TRAP_EN && nonseq && (target[1:0] != 2'b00);
        pc_next = trap ? TRAP_VECTOR : target;
    end

    // PC and instruction latch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc    <= RESET_VECTOR;
            instr <= '0;
        end else begin
            if (state == S_WAIT && imem_rvalid) instr <= imem_rdata;
            if (advance) pc <= pc_next;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q;

    // One-cycle flag following a trapped redirect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) misalign_q <= 1'b0;
        else      misalign_q <= advance && trap;
    end

    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

endmodule
